// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity encodings,
// serialiser state type and frame/baud arithmetic used at elaboration.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Widest possible frame: start + 9 data + parity + 2 stop.
    localparam int FRAME_W = 13;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_e;

    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with show-ahead read data. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; a simultaneous write and read both take effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are meaningless after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: words queue in a FIFO and are serialised
// LSB-first with optional parity and 1 or 2 stop bits. A new frame is
// loaded on the same edge the previous stop bit ends, so queued words go
// out with no idle gap.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 75000000,
    parameter int BAUD_RATE     = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int BAUD_DIV   = baud_div(CLK_FREQUENCY, BAUD_RATE);
    localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam int BCW        = $clog2(BAUD_DIV);
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [3:0]     BIT_LAST  = 4'(FRAME_BITS - 1);

    generate
        if (BAUD_DIV < 4) begin : g_bad_baud
            $error("uart_tx_buffered: BAUD_DIV must be at least 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_tx_buffered: DATA_BITS must be 5..9");
        end
        if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
            $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == PARITY_ODD) ? ~^d : ^d;
    endfunction

    tx_state_e            state_q;
    tx_state_e            state_d;
    logic [BCW-1:0]       baud_cnt;
    logic [3:0]           bit_cnt;
    logic [FRAME_W-1:0]   shift_q;
    logic [FRAME_W-1:0]   frame_word;
    logic                 tx_q;
    logic                 overflow_q;
    logic                 pop;
    logic                 load;
    logic                 finish;
    logic                 baud_tc;
    logic                 last_bit;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign baud_tc  = (baud_cnt == BAUD_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);
    assign tx_ready = ~fifo_full;
    assign uart_tx  = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q == ST_SHIFT) | (fifo_level != '0);

    // Assemble the full line image of the FIFO head word: start, data, parity, stops.
    always_comb begin
        frame_word                = '1;
        frame_word[0]             = 1'b0;
        frame_word[DATA_BITS:1]   = fifo_rd_data;
        if (PARITY != PARITY_NONE) begin
            frame_word[DATA_BITS+1] = parity_bit(fifo_rd_data);
        end
    end

    // Serialiser state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and pop/load decisions; reload at frame end keeps frames contiguous.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (baud_tc && last_bit) begin
                    if (!fifo_empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        finish  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line flop and bit timing counters; reset forces the line high mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (load) begin
            tx_q     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state_q == ST_SHIFT) begin
            if (baud_tc) begin
                baud_cnt <= '0;
                if (finish) begin
                    tx_q <= 1'b1;
                end else begin
                    tx_q    <= shift_q[0];
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + BCW'(1);
            end
        end
    end

    // Remaining frame bits; start bit goes straight to the line flop on load.
    always_ff @(posedge clk) begin
        if (load) begin
            shift_q <= {1'b1, frame_word[FRAME_W-1:1]};
        end else if (state_q == ST_SHIFT && baud_tc && !finish) begin
            shift_q <= {1'b1, shift_q[FRAME_W-1:1]};
        end
    end

    // Sticky overflow flag; a new overflow wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (tx_valid && fifo_full) begin
            overflow_q <= 1'b1;
        end else if (overflow_clr) begin
            overflow_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered: three instances (default 8N1 at 651
// cycles/bit, 7O2 fast, 8N1 fast). Line monitors decode frames into receive
// queues; tests push expected frames when they drive words and compare on pop.
module tb_uart_tx_buffered;

    typedef struct {
        logic [12:0] bits;
        bit          stable;
        int          start;
    } rx_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    logic       va = 0, vb = 0, vc = 0;
    logic [7:0] da = 0, dc = 0;
    logic [6:0] db = 0;
    logic       ca = 0, cb = 0, cc = 0;
    logic       txa, txb, txc, rdya, rdyb, rdyc, busya, busyb, busyc, ovfa, ovfb, ovfc;
    logic [4:0] lva, lvb, lvc;
    logic       line_v [3];

    rx_t         rxq_a[$], rxq_b[$], rxq_c[$];
    logic [12:0] expq_a[$], expq_b[$], expq_c[$];

    uart_tx_buffered u_a (
        .clk(clk), .rst_n(rst_n), .tx_valid(va), .tx_data(da), .tx_ready(rdya),
        .uart_tx(txa), .busy(busya), .fifo_level(lva), .overflow(ovfa), .overflow_clr(ca));

    uart_tx_buffered #(.CLK_FREQUENCY(80), .BAUD_RATE(10), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_valid(vb), .tx_data(db), .tx_ready(rdyb),
        .uart_tx(txb), .busy(busyb), .fifo_level(lvb), .overflow(ovfb), .overflow_clr(cb));

    uart_tx_buffered #(.CLK_FREQUENCY(80), .BAUD_RATE(10)) u_c (
        .clk(clk), .rst_n(rst_n), .tx_valid(vc), .tx_data(dc), .tx_ready(rdyc),
        .uart_tx(txc), .busy(busyc), .fifo_level(lvc), .overflow(ovfc), .overflow_clr(cc));

    assign line_v[0] = txa;
    assign line_v[1] = txb;
    assign line_v[2] = txc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] mk_frame(input logic [8:0] d, input int nd, input int par, input int ns);
        logic [12:0] f;
        logic        x;
        int          p;
        f    = '1;
        f[0] = 1'b0;
        x    = 1'b0;
        for (int i = 0; i < nd; i++) begin
            f[1+i] = d[i];
            x      = x ^ d[i];
        end
        p = 1 + nd;
        if (par == 1) begin f[p] = x;  p++; end
        else if (par == 2) begin f[p] = ~x; p++; end
        for (int i = 0; i < ns; i++) f[p+i] = 1'b1;
        return f;
    endfunction

    // Decode frames on one line; every cycle of every bit must hold its value.
    task automatic monitor(input int idx, input int bd, input int fb);
        rx_t r;
        bit  aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && line_v[idx] === 1'b0) begin
                r.bits   = '1;
                r.stable = 1'b1;
                r.start  = cyc;
                aborted  = 1'b0;
                for (int b = 0; b < fb && !aborted; b++) begin
                    for (int c = 0; c < bd; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
                        if (c == 0) r.bits[b] = line_v[idx];
                        else if (line_v[idx] !== r.bits[b]) r.stable = 1'b0;
                    end
                end
                if (!aborted) begin
                    case (idx)
                        0: rxq_a.push_back(r);
                        1: rxq_b.push_back(r);
                        default: rxq_c.push_back(r);
                    endcase
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_total++; if (txa !== 1'b1) $display("FAIL rst_uart_tx: got %b want 1", txa); else n_pass++;
        n_total++; if (rdya !== 1'b1) $display("FAIL rst_tx_ready: got %b want 1", rdya); else n_pass++;
        n_total++; if (busya !== 1'b0) $display("FAIL rst_busy: got %b want 0", busya); else n_pass++;
        n_total++; if (lva !== 5'd0) $display("FAIL rst_level: got %0d want 0", lva); else n_pass++;
        n_total++; if (ovfa !== 1'b0) $display("FAIL rst_overflow: got %b want 0", ovfa); else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        rx_t r;
        int  cnt;
        va = 1'b1; da = 8'hA5;
        expq_a.push_back(mk_frame({1'b0, da}, 8, 0, 1));
        step();
        va = 1'b0;
        n_total++; if (lva !== 5'd1) $display("FAIL single_level_accept: got %0d want 1", lva); else n_pass++;
        n_total++; if (txa !== 1'b1) $display("FAIL single_line_before_pop: got %b want 1", txa); else n_pass++;
        step();
        n_total++; if (txa !== 1'b0) $display("FAIL single_start_bit: got %b want 0", txa); else n_pass++;
        n_total++; if (lva !== 5'd0) $display("FAIL single_level_pop: got %0d want 0", lva); else n_pass++;
        cnt = 0;
        while (busya === 1'b1 && cnt < 7000) begin step(); cnt++; end
        n_total++; if (cnt !== 6510) $display("FAIL single_busy_cycles: got %0d want 6510", cnt); else n_pass++;
        n_total++; if (rxq_a.size() !== 1) $display("FAIL single_frame_count: got %0d want 1", rxq_a.size()); else n_pass++;
        if (rxq_a.size() > 0 && expq_a.size() > 0) begin
            r = rxq_a.pop_front();
            n_total++;
            if (r.bits !== expq_a[0] || !r.stable)
                $display("FAIL single_frame: got %h stable %0d want %h", r.bits, r.stable, expq_a[0]);
            else n_pass++;
        end
        rxq_a.delete(); expq_a.delete();
    endtask

    task automatic test_back_to_back();
        rx_t         r;
        logic [12:0] e;
        int          prev;
        va = 1'b1; da = 8'h00; expq_a.push_back(mk_frame({1'b0, da}, 8, 0, 1));
        step();
        da = 8'hFF; expq_a.push_back(mk_frame({1'b0, da}, 8, 0, 1));
        step();
        n_total++; if (lva !== 5'd1) $display("FAIL b2b_write_pop_level: got %0d want 1", lva); else n_pass++;
        da = 8'h55; expq_a.push_back(mk_frame({1'b0, da}, 8, 0, 1));
        step();
        va = 1'b0;
        n_total++; if (lva !== 5'd2) $display("FAIL b2b_level_2: got %0d want 2", lva); else n_pass++;
        repeat (6509) step();
        n_total++; if (lva !== 5'd1) $display("FAIL b2b_level_1: got %0d want 1", lva); else n_pass++;
        repeat (6510) step();
        n_total++; if (lva !== 5'd0) $display("FAIL b2b_level_0: got %0d want 0", lva); else n_pass++;
        repeat (6509) step();
        n_total++; if (busya !== 1'b1) $display("FAIL b2b_busy_last: got %b want 1", busya); else n_pass++;
        step();
        n_total++; if (busya !== 1'b0) $display("FAIL b2b_busy_done: got %b want 0", busya); else n_pass++;
        n_total++; if (rxq_a.size() !== 3) $display("FAIL b2b_frame_count: got %0d want 3", rxq_a.size()); else n_pass++;
        prev = -1;
        while (rxq_a.size() > 0 && expq_a.size() > 0) begin
            r = rxq_a.pop_front();
            e = expq_a.pop_front();
            n_total++;
            if (r.bits !== e || !r.stable) $display("FAIL b2b_frame: got %h stable %0d want %h", r.bits, r.stable, e);
            else n_pass++;
            if (prev >= 0) begin
                n_total++;
                if (r.start - prev !== 6510) $display("FAIL b2b_gap: got %0d cycles want 6510", r.start - prev);
                else n_pass++;
            end
            prev = r.start;
        end
        rxq_a.delete(); expq_a.delete();
    endtask

    task automatic test_parity();
        rx_t r;
        int  cnt;
        vb = 1'b1; db = 7'h41;
        expq_b.push_back(mk_frame({2'b00, db}, 7, 2, 2));
        step();
        vb = 1'b0;
        step();
        n_total++; if (txb !== 1'b0) $display("FAIL par_start_bit: got %b want 0", txb); else n_pass++;
        cnt = 0;
        while (busyb === 1'b1 && cnt < 500) begin step(); cnt++; end
        n_total++; if (cnt !== 88) $display("FAIL par_frame_cycles: got %0d want 88", cnt); else n_pass++;
        n_total++; if (rxq_b.size() !== 1) $display("FAIL par_frame_count: got %0d want 1", rxq_b.size()); else n_pass++;
        if (rxq_b.size() > 0 && expq_b.size() > 0) begin
            r = rxq_b.pop_front();
            n_total++;
            if (r.bits !== expq_b[0] || !r.stable)
                $display("FAIL par_frame: got %h stable %0d want %h", r.bits, r.stable, expq_b[0]);
            else n_pass++;
            n_total++; if (r.bits[8] !== 1'b1) $display("FAIL par_bit: got %b want 1", r.bits[8]); else n_pass++;
        end
        rxq_b.delete(); expq_b.delete();
    endtask

    task automatic test_overflow();
        rx_t         r;
        logic [12:0] e;
        int          cnt;
        vc = 1'b1;
        for (int i = 0; i < 17; i++) begin
            dc = 8'(i * 7 + 3);
            expq_c.push_back(mk_frame({1'b0, dc}, 8, 0, 1));
            step();
        end
        n_total++; if (rdyc !== 1'b0) $display("FAIL ovf_ready_full: got %b want 0", rdyc); else n_pass++;
        n_total++; if (lvc !== 5'd16) $display("FAIL ovf_level_full: got %0d want 16", lvc); else n_pass++;
        n_total++; if (ovfc !== 1'b0) $display("FAIL ovf_not_yet: got %b want 0", ovfc); else n_pass++;
        dc = 8'hEE;
        step();
        n_total++; if (ovfc !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovfc); else n_pass++;
        n_total++; if (lvc !== 5'd16) $display("FAIL ovf_level_kept: got %0d want 16", lvc); else n_pass++;
        cc = 1'b1;
        step();
        n_total++; if (ovfc !== 1'b1) $display("FAIL ovf_set_beats_clr: got %b want 1", ovfc); else n_pass++;
        vc = 1'b0;
        step();
        n_total++; if (ovfc !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovfc); else n_pass++;
        cc = 1'b0;
        cnt = 0;
        while (busyc === 1'b1 && cnt < 1500) begin step(); cnt++; end
        n_total++; if (busyc !== 1'b0) $display("FAIL ovf_drain_timeout: got busy %b want 0", busyc); else n_pass++;
        n_total++; if (rxq_c.size() !== 17) $display("FAIL ovf_frame_count: got %0d want 17", rxq_c.size()); else n_pass++;
        while (rxq_c.size() > 0 && expq_c.size() > 0) begin
            r = rxq_c.pop_front();
            e = expq_c.pop_front();
            n_total++;
            if (r.bits !== e || !r.stable) $display("FAIL ovf_frame: got %h stable %0d want %h", r.bits, r.stable, e);
            else n_pass++;
        end
        rxq_c.delete(); expq_c.delete();
    endtask

    task automatic test_simultaneous();
        rx_t         r;
        logic [12:0] e;
        int          cnt;
        int          prev;
        vc = 1'b1; dc = 8'h3C; expq_c.push_back(mk_frame({1'b0, dc}, 8, 0, 1));
        step();
        vc = 1'b0;
        step();
        vc = 1'b1; dc = 8'hC3; expq_c.push_back(mk_frame({1'b0, dc}, 8, 0, 1));
        step();
        vc = 1'b0;
        n_total++; if (lvc !== 5'd1) $display("FAIL sim_level_pre: got %0d want 1", lvc); else n_pass++;
        repeat (78) step();
        n_total++; if (txc !== 1'b1) $display("FAIL sim_stop_bit: got %b want 1", txc); else n_pass++;
        vc = 1'b1; dc = 8'h5A; expq_c.push_back(mk_frame({1'b0, dc}, 8, 0, 1));
        step();
        vc = 1'b0;
        n_total++; if (lvc !== 5'd1) $display("FAIL sim_write_pop_level: got %0d want 1", lvc); else n_pass++;
        n_total++; if (txc !== 1'b0) $display("FAIL sim_reload_start: got %b want 0", txc); else n_pass++;
        cnt = 0;
        while (busyc === 1'b1 && cnt < 400) begin step(); cnt++; end
        n_total++; if (busyc !== 1'b0) $display("FAIL sim_drain_timeout: got busy %b want 0", busyc); else n_pass++;
        n_total++; if (rxq_c.size() !== 3) $display("FAIL sim_frame_count: got %0d want 3", rxq_c.size()); else n_pass++;
        prev = -1;
        while (rxq_c.size() > 0 && expq_c.size() > 0) begin
            r = rxq_c.pop_front();
            e = expq_c.pop_front();
            n_total++;
            if (r.bits !== e || !r.stable) $display("FAIL sim_frame: got %h stable %0d want %h", r.bits, r.stable, e);
            else n_pass++;
            if (prev >= 0) begin
                n_total++;
                if (r.start - prev !== 80) $display("FAIL sim_gap: got %0d cycles want 80", r.start - prev);
                else n_pass++;
            end
            prev = r.start;
        end
        rxq_c.delete(); expq_c.delete();
    endtask

    task automatic test_reset_mid();
        rx_t r;
        bit  stayed_high;
        vc = 1'b1; dc = 8'h11; expq_c.push_back(mk_frame({1'b0, dc}, 8, 0, 1));
        step();
        dc = 8'h22;
        step();
        dc = 8'h33;
        step();
        vc = 1'b0;
        repeat (107) step();
        n_total++; if (txc !== 1'b0) $display("FAIL rstmid_line_before: got %b want 0", txc); else n_pass++;
        n_total++; if (lvc !== 5'd1) $display("FAIL rstmid_level_before: got %0d want 1", lvc); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (txc !== 1'b1) $display("FAIL rstmid_line_async: got %b want 1", txc); else n_pass++;
        n_total++; if (lvc !== 5'd0) $display("FAIL rstmid_level_async: got %0d want 0", lvc); else n_pass++;
        n_total++; if (busyc !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busyc); else n_pass++;
        n_total++; if (rdyc !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", rdyc); else n_pass++;
        step();
        step();
        rst_n = 1'b1;
        stayed_high = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (txc !== 1'b1) stayed_high = 1'b0;
        end
        n_total++; if (stayed_high !== 1'b1) $display("FAIL rstmid_no_frame: got line activity want idle"); else n_pass++;
        n_total++; if (busyc !== 1'b0) $display("FAIL rstmid_busy_after: got %b want 0", busyc); else n_pass++;
        n_total++; if (rxq_c.size() !== 1) $display("FAIL rstmid_frame_count: got %0d want 1", rxq_c.size()); else n_pass++;
        if (rxq_c.size() > 0 && expq_c.size() > 0) begin
            r = rxq_c.pop_front();
            n_total++;
            if (r.bits !== expq_c[0] || !r.stable)
                $display("FAIL rstmid_first_frame: got %h stable %0d want %h", r.bits, r.stable, expq_c[0]);
            else n_pass++;
        end
        rxq_c.delete(); expq_c.delete();
    endtask

    initial begin
        fork
            monitor(0, 651, 10);
            monitor(1, 8, 11);
            monitor(2, 8, 10);
        join_none
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered, parametrised UART transmitter for the comm clock domain: accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first. Frame format (data width, parity, stop bits) is set at elaboration. Consecutive frames go out back-to-back with no idle gap. The miner's result/status path uses it so that multi-byte reports can be queued in one burst instead of being paced by the serialiser.

## Interface
Parameters:
- `CLK_FREQUENCY`, 75000000: comm clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in baud.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `PARITY`, 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of two and at least 2.

Ports:
- `clk`, in, 1: comm clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `tx_valid`, in, 1: write request.
- `tx_data`, in, DATA_BITS: word to queue.
- `tx_ready`, out, 1: FIFO not full; the write is accepted when `tx_valid & tx_ready`.
- `uart_tx`, out, 1: serial line; idles high.
- `busy`, out, 1: a frame is on the line, or the FIFO is non-empty.
- `fifo_level`, out, $clog2(FIFO_DEPTH)+1: number of queued words.
- `overflow`, out, 1: sticky flag; set by a write attempt while `tx_ready` is low.
- `overflow_clr`, in, 1: clears `overflow`.

## Operation
- `BAUD_DIV = CLK_FREQUENCY/BAUD_RATE` (integer division). Each bit lasts exactly `BAUD_DIV` clk cycles.
  - Elaboration error if `BAUD_DIV < 4`, or if any parameter is out of range.
- Frame, in line order:
  - start bit (0);
  - `tx_data[0]` through `tx_data[DATA_BITS-1]`;
  - parity bit, if enabled;
  - `STOP_BITS` stop bits (1).
- `FRAME_BITS = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS`, range 7..13.
- Parity bit:
  - even mode: `^data`;
  - odd mode: `~^data`.
- Serialiser FSM has two states.
  - IDLE: `uart_tx = 1`. If the FIFO is non-empty, pop the head word, load the shift register, clear the baud counter and bit counter, and go to SHIFT.
  - SHIFT: the baud counter counts 0..BAUD_DIV-1. On the terminal count it shifts out the next bit and increments the bit counter.
    - After the last stop bit, if the FIFO is non-empty, pop and reload on the same edge and stay in SHIFT. This gives zero idle gap.
    - Otherwise go to IDLE.
- FIFO:
  - A write and a pop in the same cycle are both honoured; `fifo_level` stays unchanged.
  - There is no full-bypass: when full, `tx_ready = 0` even if a pop occurs in that cycle.
  - Pointers wrap modulo `FIFO_DEPTH`. An extra pointer bit distinguishes full from empty.
- Overflow:
  - A write attempt while full does not modify the FIFO and sets `overflow`.
  - When `overflow_clr` and a new overflow event occur in the same cycle, the set wins.
- `busy = (state == SHIFT) | (fifo_level != 0)`.

## Timing
- Reset values, applied asynchronously:
  - `uart_tx = 1`, `tx_ready = 1`, `busy = 0`, `fifo_level = 0`, `overflow = 0`;
  - FSM in IDLE.
- Reset mid-frame truncates the frame. The line returns high immediately and FIFO contents are discarded.
- `tx_ready`, `fifo_level` and `overflow` are registered and reflect state after the last edge.
- Latency with the FSM in IDLE and the FIFO empty:
  - word accepted at edge N;
  - `fifo_level = 1` after edge N;
  - pop at edge N+1, with `uart_tx` falling after edge N+1;
  - `fifo_level` back to 0 after edge N+1.
- `uart_tx` is driven directly from a flop; it carries no combinational path from inputs.
- Frame duration is exactly `FRAME_BITS * BAUD_DIV` cycles. Back-to-back frames have no extra cycles between them.

## Structure
- Package `uart_pkg` contains:
  - parity encodings `PARITY_NONE`, `PARITY_EVEN`, `PARITY_ODD`;
  - function `frame_bits(data_bits, parity, stop_bits)`;
  - function `baud_div(clk_freq, baud)`.
- Sub-module `uart_sync_fifo`: generic single-clock FIFO with parameters `WIDTH` and `DEPTH`, and ports for write, read, full, empty and level. It is instantiated once.
- The top level holds the baud counter, the bit counter, the frame shift register (13 bits max) and the overflow flag.

## Test plan
- Single word, default parameters (`BAUD_DIV = 651`):
  - write 0xA5 → `uart_tx` goes low one cycle after acceptance;
  - line sequence is 0, 1,0,1,0,0,1,0,1, 1;
  - each bit lasts 651 cycles;
  - `busy` drops after 6510 cycles.
- Burst of 3 words (0x00, 0xFF, 0x55) on consecutive cycles → `fifo_level` reaches 2, then 1, then 0, and the three frames are contiguous with no idle cycle.
- `DATA_BITS = 7`, `PARITY = 2`, `STOP_BITS = 2`, write 0x41 → parity bit 1 and frame length 11 bits.
- Overflow case:
  - fill 16 words while the line is busy, then write a 17th → `tx_ready = 0`, `overflow = 1`, and the 17th word is never transmitted;
  - pulse `overflow_clr` → `overflow = 0`.
- Simultaneous events:
  - write on the same edge as a pop with the FIFO at level 1 → level stays 1;
  - write on the same edge as `overflow_clr` while full → `overflow` stays 1.
- Assert `rst_n` low mid-data-bit of the second of two queued frames → `uart_tx = 1` immediately, `fifo_level = 0`, and no frame follows after release.
